// File: rtl/bf_pkg.sv
// Shared types and constants for the Bellman-Ford relaxation engine.
package bf_pkg;

    // Run-control states
    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StPass,
        StCheck,
        StVerify,
        StDone
    } bf_state_e;

    // Largest positive signed value at width dw; doubles as "unreachable" (dw <= 64)
    function automatic logic [63:0] inf_val(input int unsigned dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    // Most negative signed value at width dw, as a raw bit pattern (dw <= 64)
    function automatic logic [63:0] dist_min(input int unsigned dw);
        return 64'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/bf_relax_unit.sv
// Combinational relaxation of one edge: saturating add of dist[u] + w and
// signed compare against dist[v].
module bf_relax_unit
    import bf_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] dist_u_i,
    input  logic [DW-1:0] dist_v_i,
    input  logic [DW-1:0] w_i,
    output logic          upd_en_o,
    output logic [DW-1:0] upd_val_o
);

    localparam logic [DW-1:0] Inf  = DW'(inf_val(DW));
    localparam logic [DW-1:0] DMin = DW'(dist_min(DW));

    logic signed [DW:0] sum;
    logic [DW-1:0]      sat_val;

    // One extra bit of headroom so overflow in either direction is visible
    always_comb begin
        sum     = $signed({dist_u_i[DW-1], dist_u_i}) + $signed({w_i[DW-1], w_i});
        sat_val = sum[DW-1:0];
        if (sum < $signed({1'b1, DMin})) begin
            sat_val = DMin;
        end
        // A sum reaching INF would be indistinguishable from unreachable, so it is dropped
        upd_en_o  = (dist_u_i != Inf) && (sum < $signed({1'b0, Inf})) &&
                    ($signed(sat_val) < $signed(dist_v_i));
        upd_val_o = sat_val;
    end

endmodule

// File: rtl/bf_relax_engine.sv
// Bellman-Ford relaxation engine: holds the distance vector, relaxes one
// streamed edge per cycle, stops early on a quiet pass and runs one verify
// pass after N_NODES-1 passes to flag negative cycles.
module bf_relax_engine
    import bf_pkg::*;
#(
    parameter int unsigned N_NODES = 16,
    parameter int unsigned DW      = 32,
    parameter int unsigned NW      = $clog2(N_NODES),
    parameter int unsigned PW      = $clog2(N_NODES + 1)
) (
    input  logic          clk,
    input  logic          rst_global,
    input  logic          start,
    input  logic [NW-1:0] src_node,
    input  logic          edge_valid,
    output logic          edge_ready,
    input  logic [NW-1:0] edge_u,
    input  logic [NW-1:0] edge_v,
    input  logic [DW-1:0] edge_w,
    input  logic          edge_last,
    input  logic [NW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          iteration_done,
    output logic          done,
    output logic          neg_cycle,
    output logic [PW-1:0] pass_count
);

    localparam logic [DW-1:0] Inf = DW'(inf_val(DW));

    bf_state_e     state_q, state_d;
    logic [NW-1:0] src_q, src_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          changed_q, changed_d;
    logic          neg_q, neg_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          itd_q, itd_d;
    logic          done_q, done_d;

    logic [DW-1:0] dist_q [N_NODES];
    logic [DW-1:0] dist_d [N_NODES];

    logic          hs;
    logic          in_range;
    logic [DW-1:0] dist_u;
    logic [DW-1:0] dist_v;
    logic          upd_en;
    logic [DW-1:0] upd_val;
    logic          fire;

    // Operand fetch; out-of-range indices only exist when N_NODES is not a power of two
    always_comb begin
        hs       = edge_valid && ready_q;
        in_range = (32'(edge_u) < N_NODES) && (32'(edge_v) < N_NODES);
        dist_u   = in_range ? dist_q[edge_u] : Inf;
        dist_v   = in_range ? dist_q[edge_v] : Inf;
        fire     = hs && in_range && upd_en;
    end

    bf_relax_unit #(
        .DW (DW)
    ) u_relax (
        .dist_u_i  (dist_u),
        .dist_v_i  (dist_v),
        .w_i       (edge_w),
        .upd_en_o  (upd_en),
        .upd_val_o (upd_val)
    );

    // Next distance vector: seeded in INIT, one write per relaxing handshake
    always_comb begin
        dist_d = dist_q;
        if (state_q == StInit) begin
            for (int i = 0; i < N_NODES; i++) begin
                dist_d[i] = (NW'(i) == src_q) ? '0 : Inf;
            end
        end else if (fire) begin
            dist_d[edge_v] = upd_val;
        end
    end

    // Distance storage
    always_ff @(posedge clk or negedge rst_global) begin
        if (!rst_global) begin
            for (int i = 0; i < N_NODES; i++) begin
                dist_q[i] <= Inf;
            end
        end else begin
            dist_q <= dist_d;
        end
    end

    // Run-control next state and registered-output next values
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        pass_d    = pass_q;
        changed_d = changed_q;
        neg_d     = neg_q;
        itd_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit;
                    src_d   = src_node;
                end
            end
            StInit: begin
                pass_d    = '0;
                neg_d     = 1'b0;
                changed_d = 1'b0;
                state_d   = StPass;
            end
            StPass: begin
                if (fire) begin
                    changed_d = 1'b1;
                end
                if (hs && edge_last) begin
                    itd_d   = 1'b1;
                    pass_d  = pass_q + PW'(1);
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // pass_q already includes the pass that just ended
                if (!changed_q) begin
                    neg_d   = 1'b0;
                    state_d = StDone;
                end else if (pass_q == PW'(N_NODES - 1)) begin
                    changed_d = 1'b0;
                    state_d   = StVerify;
                end else begin
                    changed_d = 1'b0;
                    state_d   = StPass;
                end
            end
            StVerify: begin
                if (fire) begin
                    changed_d = 1'b1;
                end
                if (hs && edge_last) begin
                    itd_d   = 1'b1;
                    pass_d  = pass_q + PW'(1);
                    neg_d   = changed_q || fire;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StPass) || (state_d == StVerify);
        done_d  = (state_d == StDone);
    end

    // Run-control state and registered outputs
    always_ff @(posedge clk or negedge rst_global) begin
        if (!rst_global) begin
            state_q   <= StIdle;
            src_q     <= '0;
            pass_q    <= '0;
            changed_q <= 1'b0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            itd_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            pass_q    <= pass_d;
            changed_q <= changed_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            itd_q     <= itd_d;
            done_q    <= done_d;
        end
    end

    assign edge_ready     = ready_q;
    assign busy           = busy_q;
    assign iteration_done = itd_q;
    assign done           = done_q;
    assign neg_cycle      = neg_q;
    assign pass_count     = pass_q;
    assign rd_data        = (32'(rd_addr) < N_NODES) ? dist_q[rd_addr] : Inf;

endmodule

// File: tb/tb_bf_relax_engine.sv
// Self-checking bench for bf_relax_engine (N_NODES=4, DW=8): directed graphs
// plus random graphs, all checked against a pass-level Bellman-Ford model.
module tb_bf_relax_engine;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int INF  = 127;
    localparam int DMIN = -128;

    typedef struct {
        int u;
        int v;
        int w;
    } edge_t;

    logic         clk = 1'b0;
    logic         rst_global;
    logic         start;
    logic [1:0]   src_node;
    logic         edge_valid;
    logic         edge_ready;
    logic [1:0]   edge_u;
    logic [1:0]   edge_v;
    logic [W-1:0] edge_w;
    logic         edge_last;
    logic [1:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         iteration_done;
    logic         done;
    logic         neg_cycle;
    logic [2:0]   pass_count;

    int n_checks = 0;
    int n_pass   = 0;
    int itd_cnt  = 0;
    int done_cnt = 0;

    edge_t cur_edges[$];
    int    cur_src;
    int    m_dist[N];
    int    exp_passes;
    int    exp_neg;

    bf_relax_engine #(
        .N_NODES (N),
        .DW      (W)
    ) dut (
        .clk            (clk),
        .rst_global     (rst_global),
        .start          (start),
        .src_node       (src_node),
        .edge_valid     (edge_valid),
        .edge_ready     (edge_ready),
        .edge_u         (edge_u),
        .edge_v         (edge_v),
        .edge_w         (edge_w),
        .edge_last      (edge_last),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .iteration_done (iteration_done),
        .done           (done),
        .neg_cycle      (neg_cycle),
        .pass_count     (pass_count)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (iteration_done) itd_cnt++;
        if (done) done_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic add_edge(input int u, input int v, input int w);
        edge_t e;
        e.u = u;
        e.v = v;
        e.w = w;
        cur_edges.push_back(e);
    endtask

    // One sequential sweep over the edge list; returns whether anything improved
    function automatic bit relax_pass();
        bit ch = 1'b0;
        foreach (cur_edges[i]) begin
            int s;
            if (m_dist[cur_edges[i].u] == INF) continue;
            s = m_dist[cur_edges[i].u] + cur_edges[i].w;
            if (s >= INF) continue;
            if (s < DMIN) s = DMIN;
            if (s < m_dist[cur_edges[i].v]) begin
                m_dist[cur_edges[i].v] = s;
                ch = 1'b1;
            end
        end
        return ch;
    endfunction

    function automatic void compute_model();
        bit ch;
        for (int i = 0; i < N; i++) m_dist[i] = INF;
        m_dist[cur_src] = 0;
        exp_passes = 0;
        exp_neg    = 0;
        while (1) begin
            ch = relax_pass();
            exp_passes++;
            if (!ch) break;
            if (exp_passes == N - 1) begin
                ch = relax_pass();
                exp_passes++;
                exp_neg = ch;
                break;
            end
        end
    endfunction

    task automatic send_beat(input edge_t e, input bit last, inout bit ok);
        bit got = 1'b0;
        if (!ok) return;
        edge_valid = 1'b1;
        edge_u     = 2'(e.u);
        edge_v     = 2'(e.v);
        edge_w     = 8'(e.w);
        edge_last  = last;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (edge_ready) begin
                got = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        if (!got) ok = 1'b0;
    endtask

    // After a pass: either the next pass opens (ready) or the run ends (idle)
    task automatic wait_next(output bit nxt, output bit fin);
        nxt = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 8 && !nxt && !fin; c++) begin
            @(negedge clk);
            if (edge_ready) begin
                nxt = 1'b1;
                @(posedge clk);
                #1;
            end else if (!busy) begin
                fin = 1'b1;
            end
        end
    endtask

    task automatic check_dists(input string name);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            #1;
            check_eq($sformatf("%s:dist[%0d]", name, i), int'($signed(rd_data)), m_dist[i]);
        end
    endtask

    task automatic run_graph(input string name);
        int itd0, done0, n;
        bit ok, nxt, fin;
        compute_model();
        n = cur_edges.size();
        @(negedge clk);
        itd0 = itd_cnt;
        done0 = done_cnt;
        // First beat is already offered during IDLE/INIT and must not be taken early
        start      = 1'b1;
        src_node   = 2'(cur_src);
        edge_valid = 1'b1;
        edge_u     = 2'(cur_edges[0].u);
        edge_v     = 2'(cur_edges[0].v);
        edge_w     = 8'(cur_edges[0].w);
        edge_last  = (n == 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq({name, ":init_ready"}, int'(edge_ready), 0);
        check_eq({name, ":init_busy"}, int'(busy), 1);
        ok  = 1'b1;
        fin = 1'b0;
        for (int p = 0; p < N + 2 && ok && !fin; p++) begin
            for (int i = 0; i < n; i++) send_beat(cur_edges[i], i == n - 1, ok);
            if (ok) begin
                wait_next(nxt, fin);
                if (!nxt && !fin) ok = 1'b0;
            end
        end
        check_eq({name, ":completed"}, int'(ok && fin), 1);
        check_eq({name, ":pass_count"}, int'(pass_count), exp_passes);
        check_eq({name, ":neg_cycle"}, int'(neg_cycle), exp_neg);
        check_eq({name, ":iter_pulses"}, itd_cnt - itd0, exp_passes);
        check_eq({name, ":done_pulses"}, done_cnt - done0, 1);
        check_dists(name);
    endtask

    initial begin
        int done0;
        bit ok, nxt, fin;

        rst_global = 1'b0;
        start      = 1'b0;
        src_node   = '0;
        edge_valid = 1'b0;
        edge_u     = '0;
        edge_v     = '0;
        edge_w     = '0;
        edge_last  = 1'b0;
        rd_addr    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst:busy", int'(busy), 0);
        check_eq("rst:edge_ready", int'(edge_ready), 0);
        check_eq("rst:pass_count", int'(pass_count), 0);
        check_eq("rst:neg_cycle", int'(neg_cycle), 0);
        check_eq("rst:done", int'(done), 0);
        check_eq("rst:iteration_done", int'(iteration_done), 0);
        for (int i = 0; i < N; i++) m_dist[i] = INF;
        check_dists("rst");
        rst_global = 1'b1;

        // Forward chain: one productive pass then a quiet one
        cur_edges.delete();
        add_edge(0, 1, 5); add_edge(1, 2, 3); add_edge(2, 3, -2);
        cur_src = 0;
        run_graph("fwd");

        // Reverse order: one new vertex per pass, ends through VERIFY
        cur_edges.delete();
        add_edge(2, 3, -2); add_edge(1, 2, 3); add_edge(0, 1, 5);
        run_graph("rev");

        // Negative cycle 1->2->1
        cur_edges.delete();
        add_edge(0, 1, 0); add_edge(1, 2, 1); add_edge(2, 1, -3);
        run_graph("negcyc");

        // Unreachable vertex 3 with an outgoing negative edge
        cur_edges.delete();
        add_edge(0, 1, 5); add_edge(1, 2, 3); add_edge(3, 2, -5);
        run_graph("unreach");

        // Positive saturation: 100 + 100 would pass INF
        cur_edges.delete();
        add_edge(0, 1, 100); add_edge(1, 2, 100);
        run_graph("sat_hi");

        // Negative clamp: -100 + -128 clamps to -128
        cur_edges.delete();
        add_edge(0, 1, -100); add_edge(1, 2, -128);
        run_graph("sat_lo");

        // Self-loop with negative weight, different source
        cur_edges.delete();
        add_edge(1, 0, 7); add_edge(0, 0, -1);
        cur_src = 1;
        run_graph("selfloop");

        // Reset in the middle of the second pass
        cur_edges.delete();
        add_edge(0, 1, 5); add_edge(1, 2, 3); add_edge(2, 3, -2);
        cur_src = 0;
        @(negedge clk);
        done0    = done_cnt;
        start    = 1'b1;
        src_node = 2'd0;
        @(posedge clk);
        #1 start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(cur_edges[i], i == 2, ok);
        wait_next(nxt, fin);
        check_eq("midrst:second_pass", int'(nxt), 1);
        send_beat(cur_edges[0], 1'b0, ok);
        check_eq("midrst:beats_ok", int'(ok), 1);
        #2 rst_global = 1'b0;
        #1;
        check_eq("midrst:busy", int'(busy), 0);
        check_eq("midrst:edge_ready", int'(edge_ready), 0);
        check_eq("midrst:pass_count", int'(pass_count), 0);
        for (int i = 0; i < N; i++) m_dist[i] = INF;
        check_dists("midrst");
        repeat (3) @(negedge clk);
        check_eq("midrst:no_done", done_cnt - done0, 0);
        rst_global = 1'b1;
        run_graph("after_rst");

        // Random graphs
        for (int t = 0; t < 12; t++) begin
            int ne;
            cur_edges.delete();
            ne = int'($urandom_range(1, 7));
            for (int k = 0; k < ne; k++) begin
                int w;
                if ($urandom_range(0, 3) == 0) w = int'($urandom_range(0, 255)) - 128;
                else w = int'($urandom_range(0, 40)) - 12;
                add_edge(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), w);
            end
            cur_src = int'($urandom_range(0, N - 1));
            run_graph($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
